// File: rtl/button_pkg.sv
// Shared button definitions: FSM state type and default timing values
// used by button_event_gen and other button consumers.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } btn_state_t;

    // Defaults assume a 100 MHz clock and a 1 ms tick.
    localparam int unsigned DEF_TICK_DIV        = 100000;
    localparam int unsigned DEF_LONG_TICKS      = 1000;
    localparam int unsigned DEF_REP_START_TICKS = 500;
    localparam int unsigned DEF_REP_TICKS       = 100;
    localparam int unsigned DEF_TICK_W          = 17;
    localparam int unsigned DEF_HOLD_W          = 11;

endpackage

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV free-running counter with synchronous clear.
// tick is high during the cycle whose closing edge wraps the count,
// so the counter clears and the tick is consumed on the same edge.
module tick_prescaler
    import button_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned TICK_W   = DEF_TICK_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt;

    assign tick = (cnt == LAST) && !clear;

    // Count 0..TICK_DIV-1 and wrap; clear restarts the timebase at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press / release /
// long-press (and optional auto-repeat) events plus a held level.
// Define AUTO_REPEAT_EN to build the auto-repeat counter; otherwise
// rep_pulse is tied low.
module button_event_gen
    import button_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned LONG_TICKS      = DEF_LONG_TICKS,
    parameter int unsigned REP_START_TICKS = DEF_REP_START_TICKS,
    parameter int unsigned REP_TICKS       = DEF_REP_TICKS,
    parameter int unsigned TICK_W          = DEF_TICK_W,
    parameter int unsigned HOLD_W          = DEF_HOLD_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic rep_pulse,
    output logic held
);

    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_TICKS);

    btn_state_t        state;
    logic              btn_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              long_hit;

    assign rise = btn_level && !btn_q;
    assign fall = !btn_level && btn_q;

    // The tick that takes the hold count to LONG_TICKS; a same-cycle
    // fall suppresses the long event in the FSM below.
    assign long_hit = (state == HELD) && tick && (hold_cnt == LONG_LAST);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (rise),
        .tick  (tick)
    );

    // Edge detect, hold counting and press/release/long event FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            btn_q         <= 1'b0;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            held          <= 1'b0;
        end else begin
            btn_q         <= btn_level;
            press_pulse   <= rise;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HELD;
                        hold_cnt <= '0;
                        held     <= 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (long_hit) begin
                        state      <= LONG;
                        hold_cnt   <= LONG_SAT;
                        long_pulse <= 1'b1;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_FIRST = HOLD_W'(REP_START_TICKS - 1);
    localparam logic [HOLD_W-1:0] REP_NEXT  = HOLD_W'(REP_TICKS - 1);

    logic [HOLD_W-1:0] rep_cnt;
    logic              rep_armed;
    logic              rep_due;

    assign rep_due = (state != IDLE) && tick &&
                     (rep_cnt == (rep_armed ? REP_NEXT : REP_FIRST));

    // Repeat schedule advances even when a due pulse is dropped by a
    // colliding release or long event, so later repeats keep their phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_pulse <= 1'b0;
        end else begin
            rep_pulse <= rep_due && !fall && !long_hit;
            if (rise) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (rep_due) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else if (tick && state != IDLE) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen (TICK_DIV=4, LONG_TICKS=5,
// REP_START_TICKS=3, REP_TICKS=2). Honours AUTO_REPEAT_EN if defined.
module tb_button_event_gen;

    localparam int TICK_DIV  = 4;
    localparam int LONG_T    = 5;
    localparam int REP_START = 3;
    localparam int REP_T     = 2;

    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_LONG    = 3;
    localparam int K_REP     = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic reset;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic rep_pulse;
    logic held;

    int  cyc;
    int  n_cmp;
    int  n_bad;
    ev_t sb[$];

    button_event_gen #(
        .TICK_DIV        (TICK_DIV),
        .LONG_TICKS      (LONG_T),
        .REP_START_TICKS (REP_START),
        .REP_TICKS       (REP_T),
        .TICK_W          (3),
        .HOLD_W          (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .rep_pulse     (rep_pulse),
        .held          (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: after posedge E, cyc == E.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected events for a press first seen at edge r, ending at edge f
    // (release at f if rel, otherwise reset cuts the hold before f).
    task automatic plan_hold(input int r, input int f, input bit rel);
        ev_t e;
        int  d;
        e.kind = K_PRESS; e.cyc = r; sb.push_back(e);
        for (int c = r + 1; c <= f; c++) begin
            d = c - r;
            e.cyc = c;
            if (c == f) begin
                if (rel) begin
                    e.kind = K_RELEASE; sb.push_back(e);
                end
            end else if (d == LONG_T * TICK_DIV) begin
                e.kind = K_LONG; sb.push_back(e);
            end else begin
`ifdef AUTO_REPEAT_EN
                if (d >= REP_START * TICK_DIV && (d - REP_START * TICK_DIV) % (REP_T * TICK_DIV) == 0) begin
                    e.kind = K_REP; sb.push_back(e);
                end
`endif
            end
        end
    endtask

    // Press, hold for len edges, release, then confirm the queue drained.
    task automatic hold_for(input int len, input string name);
        int r;
        btn_level = 1'b1;
        r = cyc + 1;
        plan_hold(r, r + len, 1'b1);
        if (len >= 3) begin
            wait_n(2);
            check({name, " held_on"}, int'(held), 1);
            wait_n(len - 2);
        end else begin
            wait_n(len);
        end
        btn_level = 1'b0;
        wait_n(2);
        check({name, " held_off"}, int'(held), 0);
        wait_n(4);
        check({name, " drain"}, sb.size(), 0);
    endtask

    task automatic check_quiet(input string name);
        check({name, " press"},   int'(press_pulse),   0);
        check({name, " release"}, int'(release_pulse), 0);
        check({name, " long"},    int'(long_pulse),    0);
        check({name, " rep"},     int'(rep_pulse),     0);
        check({name, " held"},    int'(held),          0);
    endtask

    // Scoreboard monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        logic [3:0] p;
        ev_t e;
        if (!reset) begin
            p = {rep_pulse, long_pulse, release_pulse, press_pulse};
            if (p != 4'b0) begin
                check("onehot", $countones(p), 1);
                for (int b = 0; b < 4; b++) begin
                    if (p[b]) begin
                        if (sb.size() == 0) begin
                            check("unexpected", b + 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("kind", b + 1, e.kind);
                            check("cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int r;
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        btn_level = 1'b1;

        // Reset with the button already down.
        wait_n(3);
        check_quiet("reset");
        reset = 1'b0;
        r = cyc + 1;
        plan_hold(r, r + 3, 1'b1);
        wait_n(3);
        btn_level = 1'b0;
        wait_n(5);
        check("reset drain", sb.size(), 0);

        // Short hold: press / release only.
        wait_n(4);
        hold_for(8, "short");

        // Long hold: long once, repeats with the long collision dropped.
        hold_for(40, "long");

        // Release on the long threshold edge.
        hold_for(20, "rel_vs_long");

        // One-cycle glitch, then a fresh hold restarts timing.
        hold_for(1, "glitch");
        wait_n(2);
        hold_for(25, "repress");

        // Reset mid-hold: no release, then re-press after reset.
        btn_level = 1'b1;
        r = cyc + 1;
        plan_hold(r, r + 16, 1'b0);
        wait_n(16);
        reset = 1'b1;
        wait_n(1);
        check_quiet("midreset");
        wait_n(2);
        check("midreset drain", sb.size(), 0);
        reset = 1'b0;
        r = cyc + 1;
        plan_hold(r, r + 30, 1'b1);
        wait_n(30);
        btn_level = 1'b0;
        wait_n(5);
        check("postreset drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
